// File: rtl/axi4_s2mm_bridge_128.sv
// -----------------------------------------------------------------------------
// axi4_s2mm_bridge_128
//
// Stream-to-memory-mapped read bridge. Incoming AXI4-Stream words are buffered
// in a first-word-fall-through FIFO. Every AXI4 read burst on the slave port
// returns the next ARLEN+1 stream words in arrival order, whatever the address.
// The write channels are a stub that accepts a burst and responds OKAY, and the
// write data is discarded.
//
// Optional feature macro: AXI4_S2MM_UNDERFLOW_ZERO_EN
//   defined   : a read beat taken while the FIFO is empty returns zero data with
//               SLVERR and is counted in UNDERFLOW_CNT (saturating at 0xFFFF).
//   undefined : an empty FIFO holds RVALID low, and UNDERFLOW_CNT is tied to 0.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESET  clock; asynchronous active-high reset
//   S_AXI_AR*                 read address (only ARLEN/ARVALID are used)
//   S_AXI_R*                  read data, sourced from the FIFO head
//   S_AXI_AW*, S_AXI_W*, S_AXI_B*  write stub
//   S_AXIS_T*                 stream slave (TDATA stored, TKEEP/TLAST ignored)
//   FIFO_LEVEL                current FIFO occupancy
//   UNDERFLOW_CNT             number of zero-filled read beats
// -----------------------------------------------------------------------------
module axi4_s2mm_bridge_128 #(
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH         = 64
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  // Read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                        S_AXI_ARLEN,
  input  logic [2:0]                        S_AXI_ARSIZE,
  input  logic [1:0]                        S_AXI_ARBURST,
  input  logic                              S_AXI_ARLOCK,
  input  logic [3:0]                        S_AXI_ARCACHE,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  // Read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RLAST,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  // Write address channel (stub)
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                        S_AXI_AWLEN,
  input  logic [2:0]                        S_AXI_AWSIZE,
  input  logic [1:0]                        S_AXI_AWBURST,
  input  logic                              S_AXI_AWLOCK,
  input  logic [3:0]                        S_AXI_AWCACHE,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  // Write data channel (stub)
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WLAST,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  // Write response channel (stub)
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  // Stream slave
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  // Status
  output logic [$clog2(FIFO_DEPTH):0]       FIFO_LEVEL,
  output logic [15:0]                       UNDERFLOW_CNT
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  // FIFO storage and control
  logic [C_S_AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              r_wr_ptr;
  logic [PTR_W-1:0]              r_rd_ptr;
  logic [PTR_W:0]                r_level;

  // Read FSM
  logic [0:0]                    r_state;
  logic [7:0]                    r_len;
  logic [7:0]                    r_beat;

  // Write stub
  logic                          r_bvalid;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_in_burst;
  logic w_uflow;
  logic w_rvalid;
  logic w_rlast;
  logic w_r_hs;
  logic w_ar_hs;

  // Inputs the bridge deliberately ignores.
  logic w_unused;
  assign w_unused = &{1'b0, S_AXI_ARADDR, S_AXI_ARSIZE, S_AXI_ARBURST,
                      S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                      S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                      S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWVALID,
                      S_AXI_WDATA, S_AXI_WSTRB, S_AXIS_TKEEP, S_AXIS_TLAST};

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_FULL);
  assign w_in_burst = (r_state == S_BURST);
  assign w_push     = S_AXIS_TVALID && !w_full;

`ifdef AXI4_S2MM_UNDERFLOW_ZERO_EN
  // An empty FIFO during a burst produces a synthetic zero beat.
  assign w_uflow = w_in_burst && w_empty;
`else
  assign w_uflow = 1'b0;
`endif

  assign w_rvalid = w_in_burst && (!w_empty || w_uflow);
  assign w_rlast  = w_in_burst && (r_beat == r_len);
  assign w_r_hs   = w_rvalid && S_AXI_RREADY;
  // Synthetic beats never pop.
  assign w_pop    = w_r_hs && !w_empty;
  assign w_ar_hs  = S_AXI_ARVALID && (r_state == S_IDLE);

  // Outputs
  assign S_AXI_ARREADY = (r_state == S_IDLE);
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RLAST   = w_rlast;
  // Head is only presented while a real word is available, so reset/idle
  // and zero-fill beats all read as zero.
  assign S_AXI_RDATA   = (w_in_burst && !w_empty) ? r_mem[r_rd_ptr] : '0;
  assign S_AXI_RRESP   = w_uflow ? 2'b10 : 2'b00;
  assign S_AXI_AWREADY = !r_bvalid;
  assign S_AXI_WREADY  = !r_bvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXIS_TREADY = !w_full;
  assign FIFO_LEVEL    = r_level;

  // FIFO storage: data only, no reset needed. Writes land at the tail, which
  // differs from the head whenever the FIFO is non-empty and not full, so the
  // presented head word never changes under a push.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= S_AXIS_TDATA;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Read burst FSM
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_len   <= S_AXI_ARLEN;
            r_beat  <= '0;
            r_state <= S_BURST;
          end
        end
        default: begin
          if (w_r_hs) begin
            if (w_rlast) begin
              r_state <= S_IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Write stub: one response per WLAST, held until accepted.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_bvalid <= 1'b0;
    end else if (r_bvalid) begin
      if (S_AXI_BREADY) r_bvalid <= 1'b0;
    end else if (S_AXI_WVALID && S_AXI_WLAST) begin
      r_bvalid <= 1'b1;
    end
  end

`ifdef AXI4_S2MM_UNDERFLOW_ZERO_EN
  logic [15:0] r_ucnt;

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_ucnt <= '0;
    end else if (w_r_hs && w_uflow && (r_ucnt != 16'hFFFF)) begin
      r_ucnt <= r_ucnt + 1'b1;
    end
  end

  assign UNDERFLOW_CNT = r_ucnt;
`else
  assign UNDERFLOW_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_axi4_s2mm_bridge_128.sv
// -----------------------------------------------------------------------------
// tb_axi4_s2mm_bridge_128
//
// Directed self-checking bench for axi4_s2mm_bridge_128. Inputs are driven on
// the falling edge and outputs are sampled on the falling edge, half a cycle
// away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_axi4_s2mm_bridge_128;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int DEPTH = 64;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [DW-1:0]   tdata;
  logic            tvalid;
  logic            tready;
  logic [6:0]      level;
  logic [15:0]     ucnt;

  int checks;
  int errors;

  axi4_s2mm_bridge_128 #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (rst),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARLEN   (arlen),
    .S_AXI_ARSIZE  (3'd4),
    .S_AXI_ARBURST (2'b01),
    .S_AXI_ARLOCK  (1'b0),
    .S_AXI_ARCACHE (4'd0),
    .S_AXI_ARPROT  (3'd0),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RLAST   (rlast),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .S_AXI_AWADDR  (32'h0000_1000),
    .S_AXI_AWLEN   (8'd1),
    .S_AXI_AWSIZE  (3'd4),
    .S_AXI_AWBURST (2'b01),
    .S_AXI_AWLOCK  (1'b0),
    .S_AXI_AWCACHE (4'd0),
    .S_AXI_AWPROT  (3'd0),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   ({(DW/8){1'b1}}),
    .S_AXI_WLAST   (wlast),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TKEEP  ({(DW/8){1'b1}}),
    .S_AXIS_TLAST  (1'b0),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TREADY (tready),
    .FIFO_LEVEL    (level),
    .UNDERFLOW_CNT (ucnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream n consecutive words base, base+1, ... ; returns on a falling edge
  // after the last push has been clocked in.
  task automatic push_n(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = base + DW'(i);
    end
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  // Present an AR request for one cycle; returns on the falling edge after
  // the address handshake.
  task automatic issue_ar(input logic [7:0] len);
    @(negedge clk);
    arvalid = 1'b1;
    arlen   = len;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ar=%b aw=%b w=%b required 1 1 1", arready, awready, wready);
    end
    checks++;
    if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_r: rvalid=%b rlast=%b rdata=%h rresp=%b required 0 0 0 00",
               rvalid, rlast, rdata, rresp);
    end
    checks++;
    if (bvalid !== 1'b0 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL reset_b: bvalid=%b bresp=%b required 0 00", bvalid, bresp);
    end
    checks++;
    if (tready !== 1'b1 || level !== 7'd0 || ucnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_stream: tready=%b level=%0d ucnt=%0d required 1 0 0", tready, level, ucnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_burst;
    logic exp_last;
    push_n(128'h1, 4);
    checks++;
    if (level !== 7'd4) begin
      errors++;
      $display("FAIL basic_level_fill: level=%0d required 4", level);
    end
    rready = 1'b1;
    issue_ar(8'd3);
    checks++;
    if (arready !== 1'b0) begin
      errors++;
      $display("FAIL basic_arready_busy: arready=%b required 0", arready);
    end
    for (int i = 0; i < 4; i++) begin
      exp_last = (i == 3);
      checks++;
      if (rvalid !== 1'b1 || rdata !== DW'(i + 1) || rlast !== exp_last || rresp !== 2'b00
          || level !== 7'(4 - i)) begin
        errors++;
        $display("FAIL basic_beat%0d: rvalid=%b rdata=%h rlast=%b rresp=%b level=%0d required 1 %h %b 00 %0d",
                 i, rvalid, rdata, rlast, rresp, level, DW'(i + 1), exp_last, 4 - i);
      end
      @(negedge clk);
    end
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0 || level !== 7'd0) begin
      errors++;
      $display("FAIL basic_done: arready=%b rvalid=%b level=%0d required 1 0 0", arready, rvalid, level);
    end
    rready = 1'b0;
  endtask

  task automatic test_full;
    logic [DW-1:0] exp_d;
    push_n(128'h100, DEPTH);
    checks++;
    if (level !== 7'd64 || tready !== 1'b0) begin
      errors++;
      $display("FAIL full_flag: level=%0d tready=%b required 64 0", level, tready);
    end
    // A push offered while full must be refused.
    tvalid = 1'b1;
    tdata  = 128'hDEAD;
    @(negedge clk);
    tvalid = 1'b0;
    checks++;
    if (level !== 7'd64) begin
      errors++;
      $display("FAIL full_blocked: level=%0d required 64", level);
    end
    rready = 1'b1;
    issue_ar(8'd0);
    checks++;
    if (rdata !== 128'h100 || rlast !== 1'b1) begin
      errors++;
      $display("FAIL full_read: rdata=%h rlast=%b required 100 1", rdata, rlast);
    end
    @(negedge clk);
    checks++;
    if (tready !== 1'b1 || level !== 7'd63) begin
      errors++;
      $display("FAIL full_release: tready=%b level=%0d required 1 63", tready, level);
    end
    // Pop and push in the same cycle.
    issue_ar(8'd0);
    tvalid = 1'b1;
    tdata  = 128'h200;
    @(negedge clk);
    tvalid = 1'b0;
    checks++;
    if (level !== 7'd63) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d required 63", level);
    end
    // Drain: 0x102..0x13F then 0x200, exercising pointer wrap.
    issue_ar(8'd62);
    for (int i = 0; i < 63; i++) begin
      exp_d = (i < 62) ? DW'(32'h102 + i) : 128'h200;
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_d) begin
        errors++;
        $display("FAIL drain_beat%0d: rvalid=%b rdata=%h required 1 %h", i, rvalid, rdata, exp_d);
      end
      @(negedge clk);
    end
    checks++;
    if (level !== 7'd0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL drain_done: level=%0d arready=%b required 0 1", level, arready);
    end
    rready = 1'b0;
  endtask

  task automatic test_empty_read;
    rready = 1'b1;
    issue_ar(8'd1);
`ifdef AXI4_S2MM_UNDERFLOW_ZERO_EN
    checks++;
    if (rvalid !== 1'b1 || rdata !== '0 || rresp !== 2'b10 || rlast !== 1'b0) begin
      errors++;
      $display("FAIL uflow_beat0: rvalid=%b rdata=%h rresp=%b rlast=%b required 1 0 10 0",
               rvalid, rdata, rresp, rlast);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b1 || rdata !== '0 || rresp !== 2'b10 || rlast !== 1'b1) begin
      errors++;
      $display("FAIL uflow_beat1: rvalid=%b rdata=%h rresp=%b rlast=%b required 1 0 10 1",
               rvalid, rdata, rresp, rlast);
    end
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || ucnt !== 16'd2) begin
      errors++;
      $display("FAIL uflow_done: arready=%b ucnt=%0d required 1 2", arready, ucnt);
    end
`else
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rvalid !== 1'b0) begin
        errors++;
        $display("FAIL empty_stall%0d: rvalid=%b required 0", i, rvalid);
      end
      @(negedge clk);
    end
    push_n(128'hA1, 1);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 128'hA1 || rlast !== 1'b0 || rresp !== 2'b00) begin
      errors++;
      $display("FAIL empty_first: rvalid=%b rdata=%h rlast=%b rresp=%b required 1 a1 0 00",
               rvalid, rdata, rlast, rresp);
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0) begin
      errors++;
      $display("FAIL empty_gap: rvalid=%b arready=%b required 0 0", rvalid, arready);
    end
    push_n(128'hA2, 1);
    checks++;
    if (rvalid !== 1'b1 || rdata !== 128'hA2 || rlast !== 1'b1) begin
      errors++;
      $display("FAIL empty_second: rvalid=%b rdata=%h rlast=%b required 1 a2 1", rvalid, rdata, rlast);
    end
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || ucnt !== 16'd0 || level !== 7'd0) begin
      errors++;
      $display("FAIL empty_done: arready=%b ucnt=%0d level=%0d required 1 0 0", arready, ucnt, level);
    end
`endif
    rready = 1'b0;
  endtask

  task automatic test_back_to_back_stall;
    logic [31:0] pat;
    logic        exp_last;
    int          idx;
    int          cyc;
    pat = 32'b1011_0010_0110_1101_0011_1001_0101_1110;
    push_n(128'h300, 8);
    issue_ar(8'd7);
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 40) begin
      rready = pat[cyc];
      exp_last = (idx == 7);
      checks++;
      if (rvalid !== 1'b1 || rdata !== DW'(32'h300 + idx) || rlast !== exp_last) begin
        errors++;
        $display("FAIL stall_cyc%0d: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                 cyc, rvalid, rdata, rlast, DW'(32'h300 + idx), exp_last);
      end
      if (rvalid === 1'b1 && rready) idx++;
      @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    checks++;
    if (idx != 8 || arready !== 1'b1 || level !== 7'd0) begin
      errors++;
      $display("FAIL stall_done: beats=%0d arready=%b level=%0d required 8 1 0", idx, arready, level);
    end
  endtask

  task automatic test_reset_mid_burst;
    push_n(128'h400, 6);
    rready = 1'b1;
    issue_ar(8'd3);
    repeat (2) @(negedge clk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 128'h402 || level !== 7'd4) begin
      errors++;
      $display("FAIL midrst_pre: rvalid=%b rdata=%h level=%0d required 1 402 4", rvalid, rdata, level);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0 || rdata !== '0 || rlast !== 1'b0
        || level !== 7'd0 || tready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: arready=%b rvalid=%b rdata=%h rlast=%b level=%0d tready=%b required 1 0 0 0 0 1",
               arready, rvalid, rdata, rlast, level, tready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || level !== 7'd0 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: arready=%b level=%0d rvalid=%b required 1 0 0", arready, level, rvalid);
    end
  endtask

  task automatic test_write_stub;
    @(negedge clk);
    awvalid = 1'b1;
    wvalid  = 1'b1;
    wlast   = 1'b0;
    wdata   = 128'hCAFE;
    bready  = 1'b0;
    @(negedge clk);
    awvalid = 1'b0;
    wlast   = 1'b1;
    checks++;
    if (bvalid !== 1'b0 || wready !== 1'b1) begin
      errors++;
      $display("FAIL wr_first: bvalid=%b wready=%b required 0 1", bvalid, wready);
    end
    @(negedge clk);
    wvalid = 1'b0;
    wlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0 || bresp !== 2'b00
          || level !== 7'd0) begin
        errors++;
        $display("FAIL wr_hold%0d: bvalid=%b awready=%b wready=%b bresp=%b level=%0d required 1 0 0 00 0",
                 i, bvalid, awready, wready, bresp, level);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL wr_done: bvalid=%b awready=%b wready=%b required 0 1 1", bvalid, awready, wready);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    araddr  = 32'h4000_0000;
    arlen   = 8'd0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wdata   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    tdata   = '0;
    tvalid  = 1'b0;

    test_reset;
    test_basic_burst;
    test_full;
    test_empty_read;
    test_back_to_back_stall;
    test_reset_mid_burst;
    test_write_stub;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_s2mm_bridge_128.md
# axi4_s2mm_bridge_128

Stream-to-memory-mapped read bridge: buffers an incoming AXI4-Stream in an internal FIFO and returns its words to the processor as AXI4 read-burst data on a 128-bit HP slave port. It provides the return path that complements the write-to-stream bridge: the PS reads any address in the window and receives stream words in arrival order. The write channel is a stub that completes and discards writes.

## Interface
- C_S_AXI_DATA_WIDTH, 128, AXI and stream data width.
- C_S_AXI_ADDR_WIDTH, 32, AXI address width.
- FIFO_DEPTH, 64, stream FIFO entries; power of two, ≥2.
- S_AXI_ACLK  in  1  single clock for all logic.
- S_AXI_ARESET  in  1  reset, asynchronous and active-high.
- S_AXI_AR{ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,VALID}  in  std widths  read address; only ARLEN and ARVALID are used.
- S_AXI_ARREADY  out  1  read address accept.
- S_AXI_RDATA  out  DATA_WIDTH; S_AXI_RRESP  out  2; S_AXI_RLAST  out  1; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1  read data channel.
- S_AXI_AW*, S_AXI_W*, S_AXI_B*  std  write channels, stubbed.
- S_AXIS_TDATA  in  DATA_WIDTH; S_AXIS_TKEEP  in  DATA_WIDTH/8; S_AXIS_TLAST  in  1; S_AXIS_TVALID  in  1; S_AXIS_TREADY  out  1  stream slave.
- FIFO_LEVEL  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- UNDERFLOW_CNT  out  16  count of zero-filled read beats.

## Operation
- FIFO: stores TDATA only. TKEEP and TLAST are ignored. Push on TVALID&&TREADY; TREADY = (level != FIFO_DEPTH). Pointers wrap modulo FIFO_DEPTH. Level is one bit wider than the pointers.
- FSM states:
  - IDLE: ARREADY=1. AR handshake latches ARLEN into len, clears beat to 0, and moves to BURST.
  - BURST: ARREADY=0. R handshake pops the FIFO and increments beat. A handshake with RLAST=1 returns to IDLE.
- In BURST: RDATA = FIFO head (first-word-fall-through), RVALID = !empty, RLAST = (beat == len), RRESP = 2'b00.
- RDATA, RVALID and RLAST hold stable while RVALID=1 and RREADY=0. Pushes never alter the head while it is non-empty.
- Simultaneous push and pop: level unchanged. A push into an empty FIFO is visible at the head on the next cycle.
- Write stub:
  - AWREADY = WREADY = !BVALID.
  - A W handshake with WLAST sets BVALID. A B handshake clears it. BRESP = 2'b00. Data is discarded and the stream is untouched.
- Reset mid-burst: FSM returns to IDLE, FIFO is emptied, beat is cleared, and the in-flight burst is abandoned.

## Timing
- Reset values:
  - ARREADY=1, AWREADY=1, WREADY=1.
  - RVALID=0, RLAST=0, RDATA=0, RRESP=0, BVALID=0, BRESP=0.
  - TREADY=1, FIFO_LEVEL=0, UNDERFLOW_CNT=0.
- AR handshake in cycle N → first RVALID no earlier than N+1, exactly N+1 if the FIFO is non-empty.
- With RREADY held high and the FIFO non-empty, one beat per cycle.
- ARREADY returns high in the cycle after the last-beat handshake.
- TREADY drops in the cycle after the level reaches FIFO_DEPTH and rises in the cycle after a pop at full.
- BVALID rises in the cycle after the WLAST handshake.

## Configuration
- Macro: AXI4_S2MM_UNDERFLOW_ZERO_EN.
- Defined: in BURST with the FIFO empty, drive RVALID=1, RDATA=0, RRESP=2'b10 (SLVERR) and do not pop. The handshake counts as a beat, so bursts never stall on an empty stream. UNDERFLOW_CNT increments per such beat and saturates at 0xFFFF.
- Undefined: an empty FIFO stalls RVALID low until data arrives. UNDERFLOW_CNT is tied to 0.

## Test plan
- Push 4 words 0x…01–0x…04, then ARLEN=3 with RREADY=1 → 4 consecutive beats in order, RLAST on beat 4, RRESP=0, FIFO_LEVEL 4→0, ARREADY high again the next cycle.
- Fill to 64 → TREADY=0 and FIFO_LEVEL=64. One ARLEN=0 read → TREADY=1 the next cycle. Push and pop in the same cycle → level constant.
- ARLEN=1 issued on an empty FIFO:
  - Macro undefined: RVALID=0 until the first push; data arrives at N+1 after the push.
  - Macro defined: 2 beats of zero with RRESP=2'b10 and UNDERFLOW_CNT=2.
- RREADY toggled randomly during an 8-beat burst → RDATA and RLAST stable while stalled, no word lost or duplicated.
- Assert reset mid-burst (beat 2 of 4, FIFO=6) → all outputs at reset values asynchronously; after release ARREADY=1 and FIFO_LEVEL=0.
- 2-beat write burst with BREADY=0 for 3 cycles → BVALID held, AWREADY=WREADY=0, BRESP=0; no change to FIFO_LEVEL.
